// File: rtl/uart_rx_pkg.sv
// Shared 8N1 UART definitions: frame constants, receiver state encoding and
// baud-timing helpers. The transmitter uses the same constants.
package uart_rx_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_cnt(input int clk_freq, input int baud);
    return baud_cnt_max(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value is
// chosen per input so that reset release never looks like an edge.
module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle rx_valid / frame_err pulses.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low
// ST_START | half-bit wait, then confirm the start bit is still low
// ST_DATA  | sample 8 data bits LSB first, one per bit period
// ST_STOP  | sample the stop bit, publish byte or flag a framing error
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int HALF_CNT     = half_cnt(CLK_FREQ, BAUD);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  uart_rx_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_s == START_BIT) begin
            state    <= ST_START;
            baud_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (rx_s == START_BIT) begin
              state <= ST_DATA;
            end else begin
              // too short to be a start bit: drop it without any pulse
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt           <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) begin
              state <= ST_STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            // leave at mid-stop-bit so the next start edge is caught early
            baud_cnt <= '0;
            state    <= ST_IDLE;
            busy     <= 1'b0;
            if (rx_s == STOP_BIT) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: a bench-side serial transmitter drives
// rx, expected bytes / framing errors are queued and matched by a pulse monitor.
module tb_uart_rx;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int H        = B / 2;
  localparam int LAT      = 2 + H + 9 * B;
  localparam int P_SLOW   = (B * 103 + 50) / 100;
  localparam int P_FAST   = (B * 97 + 50) / 100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_q[$];
  int         valid_cycs[$];
  logic [7:0] last_good = 8'h00;
  int         n_err_seen = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  // Reference model: a frame yields its byte when the stop level is 1, otherwise an error (-1).
  function automatic int model_frame(input logic [7:0] d, input bit stop_level);
    return stop_level ? int'(d) : -1;
  endfunction

  always @(negedge clk) begin
    int e;
    if (resetn) begin
      if (rx_valid && frame_err) check(1'b0, "pulse_exclusive", 1, 0);
      if (rx_valid) begin
        valid_cycs.push_back(cyc);
        check(!prev_valid, "valid_width", 2, 1);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_valid", int'(rx_data), -1);
        end else begin
          e = exp_q.pop_front();
          check(e == int'(rx_data), "rx_data", int'(rx_data), e);
          if (e >= 0) last_good = e[7:0];
        end
      end
      if (frame_err) begin
        n_err_seen++;
        check(!prev_err, "err_width", 2, 1);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame_err", -1, 0);
        end else begin
          e = exp_q.pop_front();
          check(e == -1, "frame_err_expected", -1, e);
        end
        check(rx_data == last_good, "rx_data_hold", int'(rx_data), int'(last_good));
      end
    end
    prev_valid = rx_valid;
    prev_err   = frame_err;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is held low for 3/4 of the bit so its tail is rejected as a glitch.
  task automatic send_frame(input logic [7:0] d, input bit good_stop, input int p);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    if (good_stop) begin
      rx = 1'b1;
      repeat (p) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (p * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (p - p * 3 / 4) @(negedge clk);
    end
  endtask

  task automatic txq(input logic [7:0] d, input bit good_stop, input int p);
    exp_q.push_back(model_frame(d, good_stop));
    send_frame(d, good_stop, p);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(rx_data == 8'h00, {tag, "_rx_data"}, int'(rx_data), 0);
    check(rx_valid == 1'b0, {tag, "_rx_valid"}, int'(rx_valid), 0);
    check(frame_err == 1'b0, {tag, "_frame_err"}, int'(frame_err), 0);
    check(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    logic [7:0] lb_bytes[4];
    int         idx;
    int         t0;
    int         rel;
    int         errs_before;
    int         n_break_err;
    int         kind;
    int         waited;

    lb_bytes = '{8'hA5, 8'h00, 8'hFF, 8'h3C};

    @(negedge clk);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    idle(10);

    // back-to-back loopback with latency measurement on the first frame
    idx = valid_cycs.size();
    errs_before = n_err_seen;
    t0 = cyc;
    for (int i = 0; i < 4; i++) txq(lb_bytes[i], 1'b1, B);
    idle(4);
    check(valid_cycs.size() - idx == 4, "loopback_count", valid_cycs.size() - idx, 4);
    if (valid_cycs.size() > idx) begin
      check((valid_cycs[idx] - t0 - 1 >= LAT - 1) && (valid_cycs[idx] - t0 - 1 <= LAT + 1),
            "latency", valid_cycs[idx] - t0 - 1, LAT);
    end else begin
      check(1'b0, "latency_no_pulse", -1, LAT);
    end
    check(n_err_seen == errs_before, "loopback_no_err", n_err_seen - errs_before, 0);

    // short low glitch
    rx = 1'b0;
    repeat ((H * 300) / 542) @(negedge clk);
    check(busy == 1'b1, "glitch_busy_high", int'(busy), 1);
    idle(H + 8);
    check(busy == 1'b0, "glitch_busy_low", int'(busy), 0);
    check(rx_data == last_good, "glitch_rx_data", int'(rx_data), int'(last_good));

    // framing error followed by a good frame
    txq(8'h55, 1'b0, B);
    idle(H + 8);
    txq(8'h12, 1'b1, B);
    idle(B);

    // transmitter baud skew
    txq(8'hC3, 1'b1, P_FAST);
    idle(B);
    txq(8'hC3, 1'b1, P_SLOW);
    idle(B);

    // reset in the middle of bit 4 of 8'hF0
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (B) @(negedge clk);
    end
    rx = 1'b1;
    repeat (H) @(negedge clk);
    resetn = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    idle(B);
    txq(8'h81, 1'b1, B);
    idle(B);

    // break: line released just after the receiver re-enters START a fourth time
    rel = 2 + 3 * (LAT - 1) + H / 4;
    n_break_err = 0;
    for (int t = LAT; t < rel; t += LAT - 1) begin
      exp_q.push_back(-1);
      n_break_err++;
    end
    errs_before = n_err_seen;
    rx = 1'b0;
    repeat (rel) @(negedge clk);
    idle(2 * B);
    check(n_err_seen - errs_before == n_break_err, "break_err_count",
          n_err_seen - errs_before, n_break_err);
    txq(8'h7E, 1'b1, B);
    idle(B);

    // randomised traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, H - 8)) @(negedge clk);
        idle(H + 8);
      end else if (kind == 1) begin
        txq(8'($urandom), 1'b0, B);
        idle(H + 8);
      end else begin
        case ($urandom_range(0, 2))
          0:       txq(8'($urandom), 1'b1, P_FAST);
          1:       txq(8'($urandom), 1'b1, P_SLOW);
          default: txq(8'($urandom), 1'b1, B);
        endcase
        idle($urandom_range(0, H));
      end
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 4 * LAT) begin
      @(negedge clk);
      waited++;
    end
    check(exp_q.size() == 0, "drain_queue_empty", exp_q.size(), 0);
    idle(B);
    check(busy == 1'b0, "final_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
